// File: rtl/insn_decode_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : insn_decode_issue
//  Purpose  : Integer-ALU front end. Decodes raw RV64 instruction words into
//             the ALU operand bundle {regA, regB, opcode, regDest}. The bundles
//             pass through a DEPTH-entry queue with valid/ready on both sides.
//             A RUN/HALT machine stops intake once an illegal entry issues.
//  Ports    : clk, rst_n            clock, async active-low reset
//             in_valid/in_ready     fetch-side handshake
//             in_insn, in_pc        raw instruction and its PC
//             flush                 drop queue contents, return to RUN
//             out_valid/out_ready   ALU-side handshake
//             out_regA/B/opcode/regDest/pc/illegal   head-entry bundle
//             halted                machine is in HALT
//             illegal_count         saturating count of illegal issues
//  Revision : 1.0  initial release
// ============================================================================
module insn_decode_issue #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_insn,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_regA,
  output logic [11:0]      out_regB,
  output logic [9:0]       out_opcode,
  output logic [4:0]       out_regDest,
  output logic [PC_W-1:0]  out_pc,
  output logic             out_illegal,
  output logic             halted,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CNT_W = $clog2(DEPTH + 1);
  localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]   c_CNT_MAX = '1;

  typedef struct packed {
    logic            illegal;
    logic [PC_W-1:0] pc;
    logic [4:0]      rd;
    logic [9:0]      opcode;
    logic [11:0]     regb;
    logic [4:0]      rega;
  } entry_t;

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Combinational decode of the incoming word
  // --------------------------------------------------------------------------
  logic [9:0] w_opcode;
  logic [6:0] w_funct7;
  logic       w_legal;
  entry_t     w_dec;

  assign w_opcode = {in_insn[14:12], in_insn[6:0]};
  assign w_funct7 = in_insn[31:25];

  always_comb begin
    w_legal = 1'b0;
    case (w_opcode)
      10'h013, 10'h01B, 10'h393: w_legal = 1'b1;                 // ADDI, ADDIW, ANDI
      10'h03B: w_legal = (w_funct7 == 7'b0000000) ||             // ADDW
                         (w_funct7 == 7'b0000001) ||             // MULW
                         (w_funct7 == 7'b0100000);               // SUBW
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_dec         = '0;
    w_dec.illegal = ~w_legal;
    w_dec.pc      = in_pc;
    w_dec.rd      = in_insn[11:7];
    w_dec.opcode  = w_opcode;
    w_dec.regb    = in_insn[31:20];
    w_dec.rega    = in_insn[19:15];
  end

  // --------------------------------------------------------------------------
  // Queue storage and pointers
  // --------------------------------------------------------------------------
  entry_t               r_mem [DEPTH];
  entry_t               r_head;
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic                 r_out_valid;
  state_t               r_state;
  logic                 r_halted;
  logic [CNT_W-1:0]     r_illegal_cnt;

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic [c_PTR_W-1:0]   w_rd_next;
  logic [c_CNT_W-1:0]   w_count_next;
  entry_t               w_head_next;

  assign w_full   = (r_count == c_FULL);
  // in_ready never looks at out_ready, so a full queue cannot push and pop together.
  assign in_ready = rst_n & (r_state == S_RUN) & ~w_full & ~flush;
  assign w_push   = in_valid & in_ready;
  // A handshake coinciding with flush is discarded along with the queue.
  assign w_pop    = r_out_valid & out_ready & ~flush;

  assign w_rd_next    = w_pop ? (r_rd_ptr + 1'b1) : r_rd_ptr;
  assign w_count_next = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

  // The head register is preloaded with whatever entry will sit at the read
  // pointer next cycle. If that slot is being written this cycle, the incoming
  // bundle bypasses the memory so the output stays purely registered.
  always_comb begin
    w_head_next = r_mem[w_rd_next];
    if (w_push && (r_wr_ptr == w_rd_next)) begin
      w_head_next = w_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_head      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_dec;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      r_rd_ptr    <= w_rd_next;
      r_count     <= w_count_next;
      r_out_valid <= (w_count_next != '0);
      // With the queue going empty the head keeps its last value.
      if (w_count_next != '0) begin
        r_head <= w_head_next;
      end
    end
  end

  // --------------------------------------------------------------------------
  // RUN/HALT machine and illegal-issue counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_RUN;
      r_halted      <= 1'b0;
      r_illegal_cnt <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (!flush && w_pop && r_head.illegal) begin
            r_state  <= S_HALT;
            r_halted <= 1'b1;
          end
        end
        S_HALT: begin
          if (flush) begin
            r_state  <= S_RUN;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_RUN;
          r_halted <= 1'b0;
        end
      endcase
      // Entries queued behind an illegal one still drain while halted and count too.
      if (w_pop && r_head.illegal && (r_illegal_cnt != c_CNT_MAX)) begin
        r_illegal_cnt <= r_illegal_cnt + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid     = r_out_valid;
  assign out_regA      = r_head.rega;
  assign out_regB      = r_head.regb;
  assign out_opcode    = r_head.opcode;
  assign out_regDest   = r_head.rd;
  assign out_pc        = r_head.pc;
  assign out_illegal   = r_head.illegal;
  assign halted        = r_halted;
  assign illegal_count = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_insn_decode_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_insn_decode_issue
//  Purpose  : Self-checking bench for insn_decode_issue with a queue-based
//             reference model, plus a narrow-counter instance for saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_insn_decode_issue;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal, halted;
  logic [31:0] in_insn;
  logic [63:0] in_pc, out_pc;
  logic [4:0]  out_regA, out_regDest;
  logic [11:0] out_regB;
  logic [9:0]  out_opcode;
  logic [15:0] illegal_count;

  // narrow-counter instance
  logic        d2_in_valid, d2_in_ready, d2_flush, d2_out_valid, d2_out_ready;
  logic        d2_out_illegal, d2_halted;
  logic [31:0] d2_in_insn;
  logic [63:0] d2_in_pc, d2_out_pc;
  logic [4:0]  d2_out_regA, d2_out_regDest;
  logic [11:0] d2_out_regB;
  logic [9:0]  d2_out_opcode;
  logic [1:0]  d2_illegal_count;

  always #5 clk = ~clk;

  insn_decode_issue #(.DEPTH(DEPTH), .PC_W(64), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_insn(in_insn), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_regA(out_regA), .out_regB(out_regB),
    .out_opcode(out_opcode), .out_regDest(out_regDest), .out_pc(out_pc),
    .out_illegal(out_illegal), .halted(halted), .illegal_count(illegal_count)
  );

  insn_decode_issue #(.DEPTH(DEPTH), .PC_W(64), .CNT_W(2)) u_dut_cnt2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .in_insn(d2_in_insn), .in_pc(d2_in_pc), .flush(d2_flush), .out_valid(d2_out_valid),
    .out_ready(d2_out_ready), .out_regA(d2_out_regA), .out_regB(d2_out_regB),
    .out_opcode(d2_out_opcode), .out_regDest(d2_out_regDest), .out_pc(d2_out_pc),
    .out_illegal(d2_out_illegal), .halted(d2_halted), .illegal_count(d2_illegal_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] insn;
  } ent_t;

  ent_t m_q[$];
  bit   m_halted;
  int   m_cnt;

  // RISC-V view of the supported subset.
  function automatic bit ref_legal(input logic [31:0] w);
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    if (op == 7'b0010011 && (f3 == 3'd0 || f3 == 3'd7)) return 1'b1;   // ADDI / ANDI
    if (op == 7'b0011011 && f3 == 3'd0) return 1'b1;                   // ADDIW
    if (op == 7'b0111011 && f3 == 3'd0 &&
        (f7 == 7'h00 || f7 == 7'h01 || f7 == 7'h20)) return 1'b1;      // ADDW/MULW/SUBW
    return 1'b0;
  endfunction

  function automatic logic [96:0] ref_view(input ent_t e);
    return {e.pc, ~ref_legal(e.insn), e.insn[11:7], e.insn[14:12], e.insn[6:0],
            e.insn[31:20], e.insn[19:15]};
  endfunction

  function automatic logic [96:0] dut_view();
    return {out_pc, out_illegal, out_regDest, out_opcode, out_regB, out_regA};
  endfunction

  function automatic bit exp_ready(input logic fl);
    return !m_halted && (m_q.size() < DEPTH) && !fl;
  endfunction

  task automatic model_update(input logic v, input logic [31:0] insn, input logic [63:0] pc,
                              input logic rdy, input logic fl);
    bit   acc;
    ent_t e;
    if (fl) begin
      m_q.delete();
      m_halted = 1'b0;
    end else begin
      acc = v && !m_halted && (m_q.size() < DEPTH);
      if (m_q.size() > 0 && rdy) begin
        e = m_q.pop_front();
        if (!ref_legal(e.insn)) begin
          m_halted = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      if (acc) m_q.push_back('{pc: pc, insn: insn});
    end
  endtask

  task automatic check_model();
    check_eq("out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) check_eq("head", dut_view(), ref_view(m_q[0]));
    check_eq("halted", halted, m_halted);
    check_eq("illegal_count", illegal_count, 128'(m_cnt));
  endtask

  task automatic step(input logic v, input logic [31:0] insn, input logic [63:0] pc,
                      input logic rdy, input logic fl);
    @(negedge clk);
    in_valid  = v;
    in_insn   = insn;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    #1 check_eq("in_ready", in_ready, exp_ready(fl));
    @(posedge clk);
    model_update(v, insn, pc, rdy, fl);
    #1 check_model();
  endtask

  function automatic logic [31:0] gen_insn();
    int          k = $urandom_range(0, 19);
    logic [31:0] r = $urandom;
    logic [6:0]  f7s [3];
    f7s[0] = 7'h00; f7s[1] = 7'h01; f7s[2] = 7'h20;
    if (k == 0)  return r;
    if (k <= 5)  return {r[31:15], 3'b000, r[11:7], 7'h13};
    if (k <= 9)  return {r[31:15], 3'b000, r[11:7], 7'h1B};
    if (k <= 13) return {r[31:15], 3'b111, r[11:7], 7'h13};
    if (k <= 18) return {f7s[$urandom_range(0, 2)], r[24:15], 3'b000, r[11:7], 7'h3B};
    return {r[31:15], r[14:12], r[11:7], 7'h13};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int pushed;
    int cyc;
    logic        v, rdy, fl;
    logic [31:0] w;

    rst_n = 1'b0; in_valid = 0; in_insn = '0; in_pc = '0; out_ready = 0; flush = 0;
    d2_in_valid = 0; d2_in_insn = '0; d2_in_pc = '0; d2_out_ready = 0; d2_flush = 0;
    m_halted = 0; m_cnt = 0;

    // reset state
    #2;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_count", illegal_count, 0);
    check_eq("rst_data", dut_view(), 0);
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0, 0, 0);

    // T1: addi x1,x2,5
    step(1, 32'h00510093, 64'h1000, 1, 0);
    check_eq("t1_valid", out_valid, 1);
    check_eq("t1_opcode", out_opcode, 10'h013);
    check_eq("t1_regA", out_regA, 5'd2);
    check_eq("t1_regB", out_regB, 12'h005);
    check_eq("t1_rd", out_regDest, 5'd1);
    check_eq("t1_illegal", out_illegal, 0);
    step(0, 0, 0, 1, 0);

    // T2: fill with stalls, then drain in order
    step(1, 32'hFFF27193, 64'h2000, 0, 0);
    step(1, 32'h407302BB, 64'h2004, 0, 0);
    step(0, 0, 0, 0, 0);
    check_eq("t2_full_ready", in_ready, 0);
    check_eq("t2_andi_op", out_opcode, 10'h393);
    check_eq("t2_andi_regA", out_regA, 5'd4);
    check_eq("t2_andi_regB", out_regB, 12'hFFF);
    check_eq("t2_andi_rd", out_regDest, 5'd3);
    step(0, 0, 0, 1, 0);
    check_eq("t2_subw_op", out_opcode, 10'h03B);
    check_eq("t2_subw_regA", out_regA, 5'd6);
    check_eq("t2_subw_regB", out_regB, 12'h407);
    check_eq("t2_subw_rd", out_regDest, 5'd5);
    step(0, 0, 0, 1, 0);

    // T3: illegal issue halts, flush resumes
    step(1, 32'h00000000, 64'h3000, 1, 0);
    check_eq("t3_illegal", out_illegal, 1);
    step(0, 0, 0, 1, 0);
    check_eq("t3_halted", halted, 1);
    check_eq("t3_count", illegal_count, 1);
    check_eq("t3_in_ready", in_ready, 0);
    step(0, 0, 0, 0, 1);
    check_eq("t3_unhalt", halted, 0);
    step(0, 0, 0, 0, 0);
    check_eq("t3_ready_back", in_ready, 1);

    // T4: randomized traffic
    pushed = 0;
    cyc    = 0;
    while (pushed < 1000 && cyc < 20000) begin
      v   = ($urandom_range(0, 9) < 8);
      w   = gen_insn();
      rdy = ($urandom_range(0, 2) != 0);
      fl  = m_halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
      if (v && exp_ready(fl)) pushed++;
      step(v, w, {$urandom, $urandom}, rdy, fl);
      cyc++;
    end
    check_eq("t4_done", pushed >= 1000, 1);
    step(0, 0, 0, 0, 1);

    // T5: async reset with two entries queued
    step(1, 32'h00110113, 64'h5000, 0, 0);
    step(1, 32'h0021819B, 64'h5004, 0, 0);
    check_eq("t5_prefull", out_valid, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_out_valid", out_valid, 0);
    check_eq("t5_in_ready", in_ready, 0);
    check_eq("t5_count", illegal_count, 0);
    check_eq("t5_data", dut_view(), 0);
    m_q.delete(); m_halted = 0; m_cnt = 0;
    @(negedge clk) rst_n = 1'b1;
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // T6: counter saturation on a 2-bit instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d2_in_valid = 1; d2_in_insn = 32'h0; d2_in_pc = 64'(i); d2_out_ready = 1; d2_flush = 0;
      @(negedge clk) d2_in_valid = 0;
      @(negedge clk) d2_flush = 1;
      @(negedge clk) d2_flush = 0;
      #1 check_eq("t6_count", d2_illegal_count, (i + 1 > 3) ? 3 : i + 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
